// File: rtl/addr8s_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr8s_mon_pkg
// Description : Shared types, widths and golden-sum helper for the
//               8-bit signed adder fault monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package addr8s_mon_pkg;

    localparam int OPW  = 8;   // operand width
    localparam int SUMW = 9;   // exact sum width, cannot overflow

    typedef enum logic [1:0] {
        ST_MON   = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2
    } mon_state_e;

    // Exact two's-complement sum: sign-extend both operands by one bit and add.
    function automatic logic [SUMW-1:0] golden_sum(input logic [OPW-1:0] a,
                                                   input logic [OPW-1:0] b);
        return {a[OPW-1], a} + {b[OPW-1], b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/addr8s_mon_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : addr8s_mon_sat_cnt
// Description : Saturating up-counter with synchronous clear. Stops at MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module addr8s_mon_sat_cnt
    import addr8s_mon_pkg::*;
#(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority over increment; increment holds at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/addr8s_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module      : addr8s_fault_monitor
// Description : Two-stage valid/ready checker behind the 8-bit signed adder.
//               Recomputes the exact sum, flags mismatching beats, counts
//               total and consecutive mismatches and raises a sticky alarm.
//               Optional macro ADDR8S_MON_CORRECT_EN: forward the golden sum
//               in place of a faulty one (out_mis still reports the fault).
// Revision    : 1.0 - initial release
// ============================================================================
module addr8s_fault_monitor
    import addr8s_mon_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    input  logic [SUMW-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUMW-1:0]  out_sum,
    output logic             out_mis,
    input  logic             clr,
    output logic             alarm,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] C_THRESH    = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] C_THRESH_M1 = CNT_W'(THRESH - 1);

    // Stage registers
    logic            s1_v_q,   s1_v_d;
    logic [OPW-1:0]  s1_a_q,   s1_a_d;
    logic [OPW-1:0]  s1_b_q,   s1_b_d;
    logic [SUMW-1:0] s1_sum_q, s1_sum_d;
    logic            s2_v_q,   s2_v_d;
    logic [SUMW-1:0] s2_sum_q, s2_sum_d;
    logic            s2_mis_q, s2_mis_d;
    mon_state_e      state_q,  state_d;

    logic            w_s2_ready;
    logic            w_s1_adv;
    logic            w_s1_load;
    logic [SUMW-1:0] w_golden;
    logic            w_mis;
    logic            w_mis_xfer;
    logic            w_clean_xfer;
    logic [SUMW-1:0] w_fwd_sum;
    logic [CNT_W-1:0] w_consec;
    logic            w_hit;

    assign w_s2_ready   = !s2_v_q || out_ready;
    assign w_s1_adv     = s1_v_q && w_s2_ready;
    assign in_ready     = !s1_v_q || w_s2_ready;
    assign w_s1_load    = in_valid && in_ready;
    assign w_golden     = golden_sum(s1_a_q, s1_b_q);
    assign w_mis        = (w_golden != s1_sum_q);
    // Counting happens only on the S1->S2 move, so a stalled beat counts once.
    assign w_mis_xfer   = w_s1_adv && w_mis;
    assign w_clean_xfer = w_s1_adv && !w_mis;

`ifdef ADDR8S_MON_CORRECT_EN
    assign w_fwd_sum = w_mis ? w_golden : s1_sum_q;
`else
    assign w_fwd_sum = s1_sum_q;
`endif

    // Stage loads: S1 takes a new beat on handshake, S2 takes S1 when it advances.
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_sum_d = s1_sum_q;
        s2_v_d   = s2_v_q;
        s2_sum_d = s2_sum_q;
        s2_mis_d = s2_mis_q;
        if (w_s1_load) begin
            s1_v_d   = 1'b1;
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_sum_d = in_sum;
        end else if (w_s1_adv) begin
            s1_v_d   = 1'b0;
        end
        if (w_s1_adv) begin
            s2_v_d   = 1'b1;
            s2_sum_d = w_fwd_sum;
            s2_mis_d = w_mis;
        end else if (s2_v_q && out_ready) begin
            s2_v_d   = 1'b0;
        end
    end

    // Pipeline registers; only rst flushes in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sum_q <= '0;
            s2_v_q   <= 1'b0;
            s2_sum_q <= '0;
            s2_mis_q <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_sum_q <= s1_sum_d;
            s2_v_q   <= s2_v_d;
            s2_sum_q <= s2_sum_d;
            s2_mis_q <= s2_mis_d;
        end
    end

    addr8s_mon_sat_cnt #(
        .W   (CNT_W),
        .MAX ('1)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_mis_xfer),
        .cnt (err_cnt)
    );

    // A clean beat breaks the run of consecutive mismatches.
    addr8s_mon_sat_cnt #(
        .W   (CNT_W),
        .MAX (C_THRESH)
    ) u_consec_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr || w_clean_xfer),
        .inc (w_mis_xfer),
        .cnt (w_consec)
    );

    // This mismatch completes the run when the count already sits at THRESH-1.
    assign w_hit = (w_consec >= C_THRESH_M1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_MON;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decoded outputs; clr beats a concurrent mismatch.
    always_comb begin
        state_d = state_q;
        alarm   = (state_q == ST_ALARM);
        state_o = state_q;
        if (clr) begin
            state_d = ST_MON;
        end else if (w_mis_xfer) begin
            state_d = ((state_q == ST_ALARM) || w_hit) ? ST_ALARM : ST_WARN;
        end else if (w_clean_xfer && (state_q == ST_WARN)) begin
            state_d = ST_MON;
        end
    end

    assign out_valid = s2_v_q;
    assign out_sum   = s2_sum_q;
    assign out_mis   = s2_mis_q;

endmodule
`default_nettype wire
